// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder computing A + B + Cin, one bit per clock.
// A single full_adder cell is time-multiplexed over the operand bits. A registered
// carry links consecutive bits.
//
// Ports:
//   CLK   - rising-edge clock
//   RST   - synchronous, active-high reset
//   START - begin an addition (accepted in IDLE or FIN)
//   A, B  - WIDTH-bit operands, captured on the accepting edge
//   Cin   - carry-in, captured on the accepting edge
//   BUSY  - high while bits are being processed
//   DONE  - one-cycle pulse after SUM/COUT update
//   SUM   - registered low WIDTH bits of A+B+Cin
//   COUT  - registered carry-out (bit WIDTH of A+B+Cin)

// One-bit full adder cell fed by the serial sequencer.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);
    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
endmodule

module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT
);
    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_load;
    logic             w_last;
    logic             w_sum;
    logic             w_cout;

    full_adder u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FIN accepts START exactly like IDLE so additions can run back-to-back.
    always_comb begin
        w_state_next = r_state;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        w_load       = 1'b0;
        w_last       = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (START) begin
                    w_load       = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                BUSY = 1'b1;
                if (r_cnt == LAST) begin
                    w_last       = 1'b1;
                    w_state_next = StFin;
                end
            end
            StFin: begin
                DONE = 1'b1;
                if (START) begin
                    w_load       = 1'b1;
                    w_state_next = StRun;
                end else begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            SUM     <= '0;
            COUT    <= 1'b0;
        end else if (w_load) begin
            r_a_sr  <= A;
            r_b_sr  <= B;
            r_res   <= '0;
            r_carry <= Cin;
            r_cnt   <= '0;
        end else if (r_state == StRun) begin
            // LSB-first: each sum bit enters at the MSB, so after WIDTH shifts
            // bit 0 has reached position 0.
            r_a_sr  <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr  <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_res   <= {w_sum, r_res[WIDTH-1:1]};
            r_carry <= w_cout;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                SUM  <= {w_sum, r_res[WIDTH-1:1]};
                COUT <= w_cout;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=8) with hand-computed expected values.
module tb_serial_adder;
    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       START = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic       Cin = 1'b0;
    logic       BUSY;
    logic       DONE;
    logic [7:0] SUM;
    logic       COUT;

    int n_checks = 0;
    int n_pass   = 0;
    int n_overlap = 0;

    serial_adder #(.WIDTH(8)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .COUT  (COUT)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (BUSY && DONE) n_overlap++;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands and START before an edge; drop them just after it.
    task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic cin);
        START = 1'b1;
        A = a;
        B = b;
        Cin = cin;
        @(posedge CLK);
        #1;
        START = 1'b0;
        A = 8'hC3;
        B = 8'h3C;
        Cin = 1'b1;
    endtask

    // Returns at the negedge inside the DONE cycle; busy_n counts BUSY cycles seen.
    task automatic wait_done(output int busy_n, output bit seen);
        busy_n = 0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (DONE) begin
                seen = 1'b1;
                break;
            end
            if (BUSY) busy_n++;
        end
    endtask

    task automatic count_done(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge CLK);
            if (DONE) pulses++;
        end
    endtask

    task automatic run_add(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
        int  busy_n;
        bit  seen;
        do_start(a, b, cin);
        wait_done(busy_n, seen);
        check_eq({tag, "_done"}, 32'(seen), 32'd1);
        check_eq({tag, "_sum"}, 32'(SUM), 32'(exp_sum));
        check_eq({tag, "_cout"}, 32'(COUT), 32'(exp_cout));
        @(negedge CLK);
    endtask

    initial begin
        int  busy_n;
        bit  seen;
        int  pulses;

        // Reset held two cycles with START asserted.
        RST = 1'b1;
        START = 1'b1;
        A = 8'hFF;
        B = 8'hFF;
        Cin = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        START = 1'b0;
        @(negedge CLK);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_done", 32'(DONE), 32'd0);
        check_eq("rst_sum", 32'(SUM), 32'h00);
        check_eq("rst_cout", 32'(COUT), 32'd0);
        @(negedge CLK);
        check_eq("rst_nostart", 32'(BUSY), 32'd0);

        // Basic add with BUSY width, DONE width and SUM hold.
        do_start(8'h35, 8'h4A, 1'b0);
        wait_done(busy_n, seen);
        check_eq("basic_busy_cycles", 32'(busy_n), 32'd8);
        check_eq("basic_done", 32'(seen), 32'd1);
        check_eq("basic_sum", 32'(SUM), 32'h7F);
        check_eq("basic_cout", 32'(COUT), 32'd0);
        @(negedge CLK);
        check_eq("basic_done_width", 32'(DONE), 32'd0);
        check_eq("basic_sum_hold", 32'(SUM), 32'h7F);

        // Overflow and carry-in.
        run_add("ovf1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        run_add("ovf2", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        run_add("cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0);

        // Back-to-back: second START presented during the FIN cycle.
        do_start(8'h12, 8'h34, 1'b0);
        wait_done(busy_n, seen);
        check_eq("b2b_first_sum", 32'(SUM), 32'h46);
        do_start(8'h80, 8'h80, 1'b0);
        check_eq("b2b_accept", 32'(BUSY), 32'd1);
        wait_done(busy_n, seen);
        check_eq("b2b_done", 32'(seen), 32'd1);
        check_eq("b2b_edges", 32'(busy_n + 1), 32'd9);
        check_eq("b2b_sum", 32'(SUM), 32'h00);
        check_eq("b2b_cout", 32'(COUT), 32'd1);
        @(negedge CLK);

        // START during the 3rd BUSY cycle is ignored.
        do_start(8'h10, 8'h20, 1'b0);
        repeat (2) @(posedge CLK);
        #1;
        START = 1'b1;
        A = 8'hAA;
        B = 8'h55;
        @(posedge CLK);
        #1;
        START = 1'b0;
        wait_done(busy_n, seen);
        check_eq("ign_done", 32'(seen), 32'd1);
        check_eq("ign_sum", 32'(SUM), 32'h30);
        check_eq("ign_cout", 32'(COUT), 32'd0);
        count_done(15, pulses);
        check_eq("ign_one_pulse", 32'(pulses), 32'd0);

        // Reset on the 4th BUSY cycle aborts the addition.
        do_start(8'h0F, 8'hF0, 1'b1);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check_eq("abort_busy", 32'(BUSY), 32'd0);
        check_eq("abort_sum", 32'(SUM), 32'h00);
        check_eq("abort_cout", 32'(COUT), 32'd0);
        count_done(15, pulses);
        check_eq("abort_no_done", 32'(pulses), 32'd0);
        run_add("fresh", 8'h01, 8'h02, 1'b0, 8'h03, 1'b0);

        check_eq("busy_done_overlap", 32'(n_overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
